alu16: RTL and testbench

16-bit registered arithmetic/logic unit for the datapath. It takes two 16-bit signed operands and a 4-bit opcode and produces a 16-bit result, a zero flag and an overflow flag. It also keeps a MIPS-style HI/LO register pair that only multiply and divide update. Results are captured on the clock edge and presented one cycle after issue.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_muldiv.sv | 61 ++++++
 rtl/alu16.sv | 109 ++++++++++
 tb/tb_alu16.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU: datapath width and opcode encodings.
package alu_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_MUL = 4'd3,
        OP_DIV = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_NOT = 4'd8,
        OP_SLL = 4'd9,
        OP_SRA = 4'd10,
        OP_SRL = 4'd11,
        OP_SLT = 4'd12
    } opcode_t;

endpackage

// File: rtl/alu_muldiv.sv
// Combinational signed multiply / divide producing the next HI/LO pair.
// Divide-by-zero and the single quotient-overflow case are resolved here so
// the top level only has to pick this block's outputs for MUL and DIV.
module alu_muldiv
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             is_div_i,
    output logic [WIDTH-1:0] hi_next_o,
    output logic [WIDTH-1:0] lo_next_o,
    output logic             fault_o
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH:0]     a_ext;
    logic signed [WIDTH:0]     b_safe;
    logic signed [WIDTH:0]     quot;
    logic signed [WIDTH:0]     rem;
    logic                      div_by_zero;
    logic                      div_ovf;
    logic                      mul_ovf;

    // Full 32-bit signed product of the sign-extended operands.
    assign prod = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});

    // Product fits in 16 signed bits only if the upper half is the sign of the lower.
    assign mul_ovf = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});

    // Divide in 17 bits with a nonzero divisor so the arithmetic is always defined;
    // the special cases below override the result where that matters.
    assign div_by_zero = (b_i == '0);
    assign div_ovf     = (a_i == 16'h8000) && (b_i == 16'hFFFF);
    assign a_ext       = $signed({a_i[WIDTH-1], a_i});
    assign b_safe      = div_by_zero ? 17'sd1 : $signed({b_i[WIDTH-1], b_i});
    assign quot        = a_ext / b_safe;
    assign rem         = a_ext % b_safe;

    // Select the multiply or divide result, applying the divide fault cases.
    always_comb begin
        hi_next_o = prod[2*WIDTH-1:WIDTH];
        lo_next_o = prod[WIDTH-1:0];
        fault_o   = mul_ovf;
        if (is_div_i) begin
            if (div_by_zero) begin
                lo_next_o = 16'hFFFF;
                hi_next_o = a_i;
                fault_o   = 1'b1;
            end else if (div_ovf) begin
                lo_next_o = 16'h8000;
                hi_next_o = '0;
                fault_o   = 1'b1;
            end else begin
                lo_next_o = quot[WIDTH-1:0];
                hi_next_o = rem[WIDTH-1:0];
                fault_o   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu16.sv
// 16-bit registered ALU with zero/overflow flags and a HI/LO pair that only
// MUL and DIV update. Results appear one cycle after an accepted issue.
module alu16
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ins,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             ovf,
    output logic             out_valid
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [3:0]       shamt;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic             md_fault;

    assign sum   = A + B;
    assign diff  = A - B;
    assign shamt = B[3:0];

    alu_muldiv u_muldiv (
        .a_i       (A),
        .b_i       (B),
        .is_div_i  (ins == OP_DIV),
        .hi_next_o (md_hi),
        .lo_next_o (md_lo),
        .fault_o   (md_fault)
    );

    // Opcode decode: next result, HI/LO and overflow; reserved codes act as NOP.
    always_comb begin
        out_d = '0;
        hi_d  = hi_q;
        lo_d  = lo_q;
        ovf_d = 1'b0;
        case (ins)
            OP_ADD: begin
                out_d = sum;
                ovf_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                out_d = diff;
                ovf_d = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_MUL, OP_DIV: begin
                hi_d  = md_hi;
                lo_d  = md_lo;
                out_d = md_lo;
                ovf_d = md_fault;
            end
            OP_AND: out_d = A & B;
            OP_OR:  out_d = A | B;
            OP_XOR: out_d = A ^ B;
            OP_NOT: out_d = ~A;
            OP_SLL: out_d = A << shamt;
            OP_SRA: out_d = $signed(A) >>> shamt;
            OP_SRL: out_d = A >> shamt;
            OP_SLT: out_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: out_d = '0;
        endcase
        zero_d = (out_d == '0);
    end

    // Result registers load on an accepted issue and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_q  <= out_d;
                hi_q   <= hi_d;
                lo_q   <= lo_d;
                zero_q <= zero_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out       = out_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu16.sv
// Self-checking bench for alu16: directed cases from the test plan plus
// randomized issues compared against an integer-arithmetic reference model.
module tb_alu16;

    logic        clk;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  ins;
    logic        in_valid;
    logic [15:0] out;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        zero;
    logic        ovf;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_out;
    logic [15:0] m_hi;
    logic [15:0] m_lo;
    logic        m_zero;
    logic        m_ovf;

    alu16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .ins       (ins),
        .in_valid  (in_valid),
        .out       (out),
        .hi        (hi),
        .lo        (lo),
        .zero      (zero),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 16'd0; m_hi = 16'd0; m_lo = 16'd0; m_zero = 1'b1; m_ovf = 1'b0;
    endtask

    // Reference: plain integer arithmetic on the signed operand values.
    task automatic model_exec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int sa, sb, r, q, rm;
        int ua;
        int sh;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        sh = int'(b[3:0]);
        r = 0;
        m_ovf = 1'b0;
        case (op)
            4'd1: begin r = sa + sb; m_ovf = (r > 32767) || (r < -32768); end
            4'd2: begin r = sa - sb; m_ovf = (r > 32767) || (r < -32768); end
            4'd3: begin
                r = sa * sb;
                m_hi = 16'(r >>> 16);
                m_lo = 16'(r);
                m_ovf = (r > 32767) || (r < -32768);
            end
            4'd4: begin
                if (sb == 0) begin
                    q = -1; rm = sa; m_ovf = 1'b1;
                end else if (sa == -32768 && sb == -1) begin
                    q = -32768; rm = 0; m_ovf = 1'b1;
                end else begin
                    q = sa / sb; rm = sa % sb;
                end
                m_lo = 16'(q);
                m_hi = 16'(rm);
                r = q;
            end
            4'd5:  r = sa & sb;
            4'd6:  r = sa | sb;
            4'd7:  r = sa ^ sb;
            4'd8:  r = -sa - 1;
            4'd9:  r = ua * (1 << sh);
            4'd10: r = (sa < 0) ? -((-sa + (1 << sh) - 1) / (1 << sh)) : sa / (1 << sh);
            4'd11: r = ua / (1 << sh);
            4'd12: r = (sa < sb) ? 1 : 0;
            default: r = 0;
        endcase
        m_out  = 16'(r);
        m_zero = (m_out == 16'd0);
    endtask

    task automatic check_all(input string tag, input logic exp_valid);
        check({tag, ".out"}, 32'(out), 32'(m_out));
        check({tag, ".hi"}, 32'(hi), 32'(m_hi));
        check({tag, ".lo"}, 32'(lo), 32'(m_lo));
        check({tag, ".zero"}, 32'(zero), 32'(m_zero));
        check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        check({tag, ".vld"}, 32'(out_valid), 32'(exp_valid));
    endtask

    // One cycle: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        in_valid = v; ins = op; A = a; B = b;
        @(posedge clk);
        #1;
        if (v) model_exec(op, a, b);
        $display("txn v=%0d op=%0d A=%0h B=%0h -> out=%0h hi=%0h lo=%0h z=%0d o=%0d",
                 v, op, a, b, out, hi, lo, zero, ovf);
        check_all($sformatf("op%0d", op), v);
    endtask

    function automatic logic [15:0] pick_operand();
        logic [15:0] v;
        case ($urandom_range(0, 7))
            0: v = 16'h8000;
            1: v = 16'h7FFF;
            2: v = 16'hFFFF;
            3: v = 16'h0000;
            4: v = 16'(int'($urandom_range(0, 8)));
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; ins = 4'd0; A = 16'd0; B = 16'd0;
        model_reset();
        #12;
        check_all("reset", 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Base check A=511, B=3, opcodes 1..9
        for (int op = 1; op <= 9; op++) begin
            step(1'b1, 4'(op), 16'd511, 16'd3);
            if (op == 1) check("plan_add", 32'(out), 32'd514);
            if (op == 4) begin
                check("plan_div_lo", 32'(lo), 32'd170);
                check("plan_div_hi", 32'(hi), 32'd1);
            end
        end
        check("plan_sll", 32'(out), 32'd4088);
        check("plan_hold_lo", 32'(lo), 32'd170);

        // Overflow and signed mul/div
        step(1'b1, 4'd1, 16'h7FFF, 16'd1);
        check("plan_add_ovf", 32'(ovf), 32'd1);
        step(1'b1, 4'd2, 16'h8000, 16'd1);
        step(1'b1, 4'd3, 16'(-300), 16'd200);
        check("plan_mul_lo", 32'(lo), 32'h15A0);
        step(1'b1, 4'd4, 16'(-7), 16'd2);
        check("plan_div_neg", 32'(lo), 32'hFFFD);
        step(1'b1, 4'd4, 16'd5, 16'd0);
        step(1'b1, 4'd4, 16'h8000, 16'hFFFF);

        // Handshake and hold
        step(1'b1, 4'd1, 16'd511, 16'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 4'd2, 16'd1, 16'd1);
        check("hold_out", 32'(out), 32'd514);

        // Reset asserted between edges mid-stream
        step(1'b1, 4'd3, 16'd1234, 16'd77);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midreset", 1'b0);
        @(posedge clk); #2;
        check_all("inreset", 1'b0);
        rst_n = 1'b1;
        step(1'b1, 4'd1, 16'd100, 16'd23);

        // Randomized issues with occasional idle cycles
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 4) != 0), 4'($urandom_range(0, 15)), pick_operand(), pick_operand());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
